// File: rtl/regfile32_wr_demux_pkg.sv
// rtl/regfile32_wr_demux_pkg.sv - shared register-bank sizes and one-hot helper
//
// Purpose: constants shared by the register bank write path, its decoder and
// the bus interface, plus the one-hot encode used by the write decoder.
// Ports: none (package).

package regfile_pkg;

    localparam int REG_W        = 32;   // entry width
    localparam int REG_N        = 32;   // number of entries
    localparam int REG_AW       = 5;    // entry index width
    localparam int REG_ZERO_IDX = 0;    // index of the hard-wired zero entry
    localparam int WCNT_W       = 16;   // accepted-write counter width

    function automatic logic [REG_N-1:0] onehot(input logic [REG_AW-1:0] idx);
        logic [REG_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile32_wr_demux_if.sv
// rtl/regfile32_wr_demux_if.sv - write-port and flat-readout bundle of the register bank
//
// Purpose: groups the write request (ena/iWe/iWaddr/iWdata) with the bank
// outputs (oRegs/oWritten/oWcount/oWack).
// Modports:
//   master - drives the write request, observes the bank outputs
//   slave  - the register bank itself

interface regfile32_wr_demux_if;
    import regfile_pkg::*;

    logic                    ena;
    logic                    iWe;
    logic [REG_AW-1:0]       iWaddr;
    logic [REG_W-1:0]        iWdata;
    logic [REG_N*REG_W-1:0]  oRegs;
    logic [REG_N-1:0]        oWritten;
    logic [WCNT_W-1:0]       oWcount;
    logic                    oWack;

    modport master (
        output ena, iWe, iWaddr, iWdata,
        input  oRegs, oWritten, oWcount, oWack
    );

    modport slave (
        input  ena, iWe, iWaddr, iWdata,
        output oRegs, oWritten, oWcount, oWack
    );

endinterface

// File: rtl/regfile32_wr_demux_decoder5_32.sv
// rtl/regfile32_wr_demux_decoder5_32.sv - combinational 5:32 one-hot decoder
//
// Purpose: turns an entry index into a one-hot write-enable vector; all zeros
// when disabled. Write-side mirror of the bank's 32:1 read selector.
// Ports:
//   iA   in  5   entry index
//   ena  in  1   decoder enable
//   oY   out 32  one-hot select (at most one bit high)

module decoder5_32
    import regfile_pkg::*;
(
    input  logic [REG_AW-1:0] iA,
    input  logic              ena,
    output logic [REG_N-1:0]  oY
);

    // The address is only looked at while enabled, so an unknown index with
    // ena low still yields an all-zero vector.
    always_comb begin
        oY = '0;
        if (ena) begin
            oY = onehot(iA);
        end
    end

endmodule

// File: rtl/regfile32_wr_demux.sv
// rtl/regfile32_wr_demux.sv - register bank write side: 1:32 demux, entries, written map, counter
//
// Purpose: decodes the write index one-hot and loads the addressed entry on the
// rising edge; exposes all entries on a flat bus for the bank's read selectors.
// Also keeps a sticky written bitmap, a saturating accepted-write counter and a
// one-cycle write acknowledge.
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset, wins over a same-cycle write
//   bus  slave modport: ena, iWe, iWaddr, iWdata in;
//        oRegs (entry k at [32k+31:32k]), oWritten, oWcount, oWack out

module regfile32_wr_demux
    import regfile_pkg::*;
#(
    parameter int WIDTH   = REG_W,
    parameter int DEPTH   = REG_N,   // fixed at 2**AW
    parameter int AW      = REG_AW,
    parameter bit ZERO_R0 = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst,
    regfile32_wr_demux_if.slave  bus
);

    // Entries masked out of the write path. With ZERO_R0 the zero entry is
    // never loaded, so it keeps its reset value of 0 forever.
    localparam logic [DEPTH-1:0] RO_MASK =
        ZERO_R0 ? (DEPTH'(1) << REG_ZERO_IDX) : '0;

    logic [DEPTH-1:0]  weVec;
    logic [DEPTH-1:0]  weMask;
    logic              accepted;
    logic [WIDTH-1:0]  entry [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [WCNT_W-1:0] wcount;
    logic              wack;

    decoder5_32 uDecoder (
        .iA  (bus.iWaddr),
        .ena (bus.ena & bus.iWe),
        .oY  (weVec)
    );

    // A write is accepted exactly when it selects a writable entry.
    assign weMask   = weVec & ~RO_MASK;
    assign accepted = |weMask;

    for (genvar k = 0; k < DEPTH; k++) begin : gEntry
        always_ff @(posedge clk) begin
            if (rst) begin
                entry[k] <= '0;
            end else if (weMask[k]) begin
                entry[k] <= bus.iWdata;
            end
        end
        assign bus.oRegs[k*WIDTH +: WIDTH] = entry[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written <= '0;
            wcount  <= '0;
            wack    <= 1'b0;
        end else begin
            written <= written | weMask;
            wack    <= accepted;
            if (accepted && (wcount != '1)) begin
                wcount <= wcount + 1'b1;
            end
        end
    end

    assign bus.oWritten = written;
    assign bus.oWcount  = wcount;
    assign bus.oWack    = wack;

endmodule

// File: tb/tb_regfile32_wr_demux.sv
// tb/tb_regfile32_wr_demux.sv - self-checking bench for regfile32_wr_demux

module tb_regfile32_wr_demux;
    import regfile_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile32_wr_demux_if bus ();

    regfile32_wr_demux #(
        .WIDTH   (32),
        .DEPTH   (32),
        .AW      (5),
        .ZERO_R0 (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    wr_t         sb[$];
    logic [31:0] mRegs [32];
    logic [31:0] mWritten;
    int          mCount;
    logic        pendAcc;
    logic        expAck;
    int          ackRun;

    always @(posedge clk) begin
        if (bus.ena === 1'b1 && bus.iWe === 1'b1 && $isunknown(bus.iWaddr)) begin
            fails++;
            $display("FAIL waddr_known: iWaddr=%b while ena&iWe", bus.iWaddr);
        end
    end

    function automatic logic [31:0] selEntry(input logic [1023:0] regs, input int idx);
        return regs[idx*32 +: 32];
    endfunction

    // Runs at every negedge: checks the ack of the previous edge and pops the
    // scoreboard for each acknowledged write.
    task automatic observe();
        wr_t w;
        expAck = pendAcc;
        tests++;
        if (bus.oWack !== expAck) begin
            fails++;
            $display("FAIL wack: got %b expected %b at %0t", bus.oWack, expAck, $time);
        end
        if (bus.oWack === 1'b1) begin
            ackRun++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: ack with empty scoreboard at %0t", $time);
            end else begin
                w = sb.pop_front();
                if (selEntry(bus.oRegs, int'(w.addr)) !== w.data) begin
                    fails++;
                    $display("FAIL ack_data[%0d]: got %h expected %h", w.addr,
                             selEntry(bus.oRegs, int'(w.addr)), w.data);
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic we,
                       input logic [4:0] a, input logic [31:0] d);
        logic acc;
        @(negedge clk);
        observe();
        rst        = r;
        bus.ena    = e;
        bus.iWe    = we;
        bus.iWaddr = a;
        bus.iWdata = d;
        acc = !r && e && we && (a != 5'd0);
        if (r) begin
            for (int i = 0; i < 32; i++) mRegs[i] = '0;
            mWritten = '0;
            mCount   = 0;
        end else if (acc) begin
            mRegs[a]    = d;
            mWritten[a] = 1'b1;
            if (mCount < 65535) mCount++;
            sb.push_back('{a, d});
        end
        pendAcc = acc;
    endtask

    task automatic settle();
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkAll(input string name);
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (selEntry(bus.oRegs, i) !== mRegs[i]) begin
                fails++;
                $display("FAIL %s entry[%0d]: got %h expected %h", name, i,
                         selEntry(bus.oRegs, i), mRegs[i]);
            end
        end
        tests++;
        if (bus.oWritten !== mWritten) begin
            fails++;
            $display("FAIL %s written: got %h expected %h", name, bus.oWritten, mWritten);
        end
        tests++;
        if (bus.oWcount !== 16'(mCount)) begin
            fails++;
            $display("FAIL %s wcount: got %0d expected %0d", name, bus.oWcount, mCount);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s ack_missing: %0d writes not acknowledged", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        settle();
        checkAll("reset");
    endtask

    task automatic test_single_write();
        cyc(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234_5678);
        settle();
        checkAll("single");
        tests++;
        if (selEntry(bus.oRegs, 5) !== 32'h1234_5678 || bus.oWritten !== 32'h0000_0020) begin
            fails++;
            $display("FAIL single_const: entry5=%h written=%h expected 12345678/00000020",
                     selEntry(bus.oRegs, 5), bus.oWritten);
        end
        settle();
    endtask

    task automatic test_zero_guard();
        cyc(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        settle();
        checkAll("zero_guard");
        tests++;
        if (selEntry(bus.oRegs, 0) !== 32'd0 || bus.oWritten[0] !== 1'b0) begin
            fails++;
            $display("FAIL zero_const: entry0=%h written0=%b expected 0/0",
                     selEntry(bus.oRegs, 0), bus.oWritten[0]);
        end
    endtask

    task automatic test_ena_gating();
        cyc(1'b0, 1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5);
        settle();
        checkAll("ena_off");
        cyc(1'b0, 1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5);
        settle();
        checkAll("ena_on");
    endtask

    task automatic test_x_addr();
        cyc(1'b0, 1'b1, 1'b0, 5'bxxxxx, 32'h5555_5555);
        settle();
        checkAll("x_addr");
    endtask

    task automatic test_same_addr();
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_AAAA);
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_BBBB);
        settle();
        checkAll("same_addr");
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        settle();
        ackRun = 0;
        for (int k = 1; k < 32; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 5'(k), 32'(k) * 32'h0101_0101);
        end
        settle();
        checkAll("sweep");
        tests++;
        if (ackRun != 31 || bus.oWritten !== 32'hFFFF_FFFE || bus.oWcount !== 16'd31) begin
            fails++;
            $display("FAIL sweep_const: acks=%0d written=%h wcount=%0d expected 31/fffffffe/31",
                     ackRun, bus.oWritten, bus.oWcount);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 70000; n++) begin
            cyc(1'b0, 1'b1, 1'b1, 5'(1 + n % 31), 32'(n));
        end
        settle();
        checkAll("saturate");
        tests++;
        if (bus.oWcount !== 16'hFFFF) begin
            fails++;
            $display("FAIL saturate_const: wcount=%h expected ffff", bus.oWcount);
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b0, 1'b1, 1'b1, 5'd2, 32'h2222_2222);
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'h3333_3333);
        cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'h4444_4444);
        cyc(1'b0, 1'b1, 1'b1, 5'd8, 32'h8888_8888);
        settle();
        checkAll("mid_reset");
        tests++;
        if (bus.oWcount !== 16'd1 || bus.oWritten !== 32'h0000_0100) begin
            fails++;
            $display("FAIL mid_reset_const: wcount=%0d written=%h expected 1/00000100",
                     bus.oWcount, bus.oWritten);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.iWe    = 1'b1;
        bus.iWaddr = 5'd3;
        bus.iWdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mWritten = '0;
        mCount   = 0;
        pendAcc  = 1'b0;
        expAck   = 1'b0;
        ackRun   = 0;

        test_reset();
        test_single_write();
        test_zero_guard();
        test_ena_gating();
        test_x_addr();
        test_same_addr();
        test_back_to_back();
        test_saturation();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
